// File: rtl/rv_data_mem.sv
// Byte-addressable RV32 data memory: valid/ready requests, READ_LAT-deep response pipe.
// Define RV_DMEM_MISALIGN_TRAP_EN to report misaligned halfword/word accesses as errors.
module rv_data_mem #(
  parameter int unsigned DEPTH_WORDS = 2048,
  parameter int unsigned READ_LAT    = 1,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AddrW     = $clog2(DEPTH_WORDS);
  localparam logic [32:0] AddrLimit = 33'(DEPTH_WORDS) << 2;
  localparam int          PipeN     = int'(READ_LAT) - 1;

  logic [31:0] mem [DEPTH_WORDS];

  logic             accept, req_err, f3_ok, range_err, size_half, size_word, we;
  logic [1:0]       lane;
  logic [3:0]       be;
  logic [31:0]      wdata_rep;
  logic [AddrW-1:0] word_idx;

  assign req_ready = !reset;
  assign accept    = req_valid && req_ready;
  assign size_half = (req_funct3[1:0] == 2'b01);
  assign size_word = (req_funct3[1:0] == 2'b10);
  assign range_err = {1'b0, req_addr} >= AddrLimit;
  assign word_idx  = req_addr[AddrW+1:2];

  always_comb begin
    if (req_write) f3_ok = (req_funct3 < 3'b011);
    else           f3_ok = req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  end

`ifdef RV_DMEM_MISALIGN_TRAP_EN
  logic misalign;
  assign misalign = (size_half && req_addr[0]) || (size_word && (req_addr[1:0] != 2'b00));
  assign req_err  = !f3_ok || range_err || misalign;
  assign lane     = req_addr[1:0];
`else
  // Misaligned accesses silently round down to the natural boundary.
  assign req_err  = !f3_ok || range_err;
  assign lane     = size_word ? 2'b00 : (size_half ? {req_addr[1], 1'b0} : req_addr[1:0]);
`endif

  always_comb begin
    be        = 4'b0001 << lane;
    wdata_rep = {4{req_wdata[7:0]}};
    if (size_word) begin
      be        = 4'b1111;
      wdata_rep = req_wdata;
    end else if (size_half) begin
      be        = lane[1] ? 4'b1100 : 4'b0011;
      wdata_rep = {2{req_wdata[15:0]}};
    end
  end

  assign we = accept && req_write && !req_err;

  // Single-port synchronous RAM; no reset so it maps onto block RAM.
  logic [31:0] ram_q;
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[word_idx][8*i +: 8] <= wdata_rep[8*i +: 8];
      end
    end
    ram_q <= mem[word_idx];
  end

  logic       s0_valid_q, s0_err_q, s0_load_q;
  logic [2:0] s0_funct3_q;
  logic [1:0] s0_lane_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s0_valid_q  <= 1'b0;
      s0_err_q    <= 1'b0;
      s0_load_q   <= 1'b0;
      s0_funct3_q <= 3'b000;
      s0_lane_q   <= 2'b00;
    end else begin
      s0_valid_q  <= accept;
      s0_err_q    <= req_err;
      s0_load_q   <= !req_write;
      s0_funct3_q <= req_funct3;
      s0_lane_q   <= lane;
    end
  end

  // Lane extraction sits after the RAM register so the read stays in block RAM.
  logic [31:0] s0_rdata;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic        s0_err;

  assign lane_byte = ram_q[{s0_lane_q, 3'b000} +: 8];
  assign lane_half = ram_q[{s0_lane_q[1], 4'b0000} +: 16];
  assign s0_err    = s0_valid_q && s0_err_q;

  always_comb begin
    s0_rdata = '0;
    if (s0_valid_q && s0_load_q && !s0_err_q) begin
      case (s0_funct3_q)
        3'b000:  s0_rdata = {{24{lane_byte[7]}}, lane_byte};
        3'b001:  s0_rdata = {{16{lane_half[15]}}, lane_half};
        3'b010:  s0_rdata = ram_q;
        3'b100:  s0_rdata = {24'b0, lane_byte};
        3'b101:  s0_rdata = {16'b0, lane_half};
        default: s0_rdata = '0;
      endcase
    end
  end

  if (READ_LAT > 1) begin : g_pipe
    logic        v_q [PipeN];
    logic [31:0] d_q [PipeN];
    logic        e_q [PipeN];

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < PipeN; i++) begin
          v_q[i] <= 1'b0;
          d_q[i] <= '0;
          e_q[i] <= 1'b0;
        end
      end else begin
        v_q[0] <= s0_valid_q;
        d_q[0] <= s0_rdata;
        e_q[0] <= s0_err;
        for (int i = 1; i < PipeN; i++) begin
          v_q[i] <= v_q[i-1];
          d_q[i] <= d_q[i-1];
          e_q[i] <= e_q[i-1];
        end
      end
    end

    assign resp_valid = v_q[PipeN-1];
    assign resp_rdata = d_q[PipeN-1];
    assign resp_err   = e_q[PipeN-1];
  end else begin : g_direct
    assign resp_valid = s0_valid_q;
    assign resp_rdata = s0_rdata;
    assign resp_err   = s0_err;
  end

endmodule

// File: tb/tb_rv_data_mem.sv
// Bench for rv_data_mem: one stimulus stream drives three instances (READ_LAT 1, 3, 4)
// and every response cycle is compared with a byte-array reference model.
module tb_rv_data_mem;

  localparam int unsigned Depth = 64;
  localparam int          MaxE  = 4096;

  logic        clk;
  logic        reset;
  logic        req_valid, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        ready  [3];
  logic        resp_v [3];
  logic [31:0] resp_d [3];
  logic        resp_e [3];

  int lats [3] = '{1, 3, 4};

  rv_data_mem #(.DEPTH_WORDS(Depth), .READ_LAT(1), .INIT_FILE("")) u_dut_l1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready[0]),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_v[0]), .resp_rdata(resp_d[0]),
    .resp_err(resp_e[0])
  );

  rv_data_mem #(.DEPTH_WORDS(Depth), .READ_LAT(3), .INIT_FILE("")) u_dut_l3 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready[1]),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_v[1]), .resp_rdata(resp_d[1]),
    .resp_err(resp_e[1])
  );

  rv_data_mem #(.DEPTH_WORDS(Depth), .READ_LAT(4), .INIT_FILE("")) u_dut_l4 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready[2]),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_v[2]), .resp_rdata(resp_d[2]),
    .resp_err(resp_e[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int ecnt    = 0;
  bit mon_en  = 1'b0;

  // Per-edge record of what was accepted and what it must return.
  bit        rec_v  [MaxE];
  bit [31:0] rec_d  [MaxE];
  bit        rec_e  [MaxE];
  bit        rst_at [MaxE];
  bit [7:0]  mem_m  [4*Depth];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model(input bit w, input bit [2:0] f3, input bit [31:0] a,
                                input bit [31:0] wd, output bit err, output bit [31:0] rd);
    int size;
    bit legal;
    longint unsigned addr, v;
    size  = 1 << f3[1:0];
    legal = w ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    addr  = longint'(a);
    err   = !legal || (addr >= 4 * Depth);
`ifdef RV_DMEM_MISALIGN_TRAP_EN
    if (addr % size != 0) err = 1'b1;
`else
    addr = addr - (addr % size);
`endif
    rd = '0;
    if (!err) begin
      if (w) begin
        for (int i = 0; i < size; i++) mem_m[int'(addr) + i] = wd[8*i +: 8];
      end else begin
        v = 0;
        for (int i = 0; i < size; i++) v = v | (longint'(mem_m[int'(addr) + i]) << (8 * i));
        if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~((64'd1 << (8 * size)) - 1);
        rd = v[31:0];
      end
    end
  endfunction

  always @(posedge clk) ecnt++;

  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < 3; d++) begin
        int k;
        bit ev;
        k  = ecnt - lats[d] + 1;
        ev = (k >= 1) && rec_v[k];
        for (int j = k + 1; j <= ecnt; j++) if (j >= 1 && rst_at[j]) ev = 1'b0;
        check($sformatf("lat%0d_valid", lats[d]), 32'(resp_v[d]), 32'(ev));
        check($sformatf("lat%0d_rdata", lats[d]), resp_d[d], ev ? rec_d[k] : 32'h0);
        check($sformatf("lat%0d_err", lats[d]), 32'(resp_e[d]), ev ? 32'(rec_e[k]) : 32'h0);
      end
    end
  end

  // Called at a falling edge; presents one cycle of inputs, returns at the next falling edge.
  task automatic drive(input bit rst, input bit v, input bit w, input bit [2:0] f3,
                       input bit [31:0] a, input bit [31:0] wd);
    int e;
    bit err;
    bit [31:0] rd;
    e          = ecnt + 1;
    reset      = rst;
    req_valid  = v;
    req_write  = w;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    rst_at[e]  = rst;
    rec_v[e]   = 1'b0;
    if (!rst && v) begin
      model(w, f3, a, wd, err, rd);
      rec_v[e] = 1'b1;
      rec_d[e] = rd;
      rec_e[e] = err;
    end
    #1;
    for (int d = 0; d < 3; d++) check("req_ready", 32'(ready[d]), 32'(!rst));
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
  endtask

  initial begin
    bit [2:0]  f3;
    bit [31:0] a;
    bit        w;
    bit [2:0]  ld_ok [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    drive(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    drive(1'b1, 1'b1, 1'b1, 3'b010, 32'h0, 32'h0);
    mon_en = 1'b1;

    // RAM has no defined power-up contents; give every word a known value.
    for (int i = 0; i < Depth; i++) drive(1'b0, 1'b1, 1'b1, 3'b010, 32'(4 * i), $urandom);
    idle(4);

    // Checks on the READ_LAT=1 instance are made in the cycle after acceptance.
    drive(1'b0, 1'b1, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    drive(1'b0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    check("sw_lw_data", resp_d[0], 32'hDEADBEEF);
    check("sw_lw_err", 32'(resp_e[0]), 32'h0);

    drive(1'b0, 1'b1, 1'b1, 3'b010, 32'h20, 32'h0);
    drive(1'b0, 1'b1, 1'b1, 3'b000, 32'h21, 32'h80);
    drive(1'b0, 1'b1, 1'b1, 3'b001, 32'h22, 32'hFF7F);
    check("sh_resp_data", resp_d[0], 32'h0);
    drive(1'b0, 1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
    check("lw_bytes", resp_d[0], 32'hFF7F8000);
    drive(1'b0, 1'b1, 1'b0, 3'b000, 32'h21, 32'h0);
    check("lb_sext", resp_d[0], 32'hFFFFFF80);
    drive(1'b0, 1'b1, 1'b0, 3'b100, 32'h21, 32'h0);
    check("lbu_zext", resp_d[0], 32'h00000080);
    drive(1'b0, 1'b1, 1'b0, 3'b001, 32'h22, 32'h0);
    check("lh_sext", resp_d[0], 32'hFFFFFF7F);

    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 1'b0, 3'b010, 32'(4 * i), 32'h0);
    idle(4);

    drive(1'b0, 1'b1, 1'b0, 3'b010, 32'(4 * Depth), 32'h0);
    check("range_err", 32'(resp_e[0]), 32'h1);
    check("range_rdata", resp_d[0], 32'h0);
    drive(1'b0, 1'b1, 1'b1, 3'b011, 32'h10, 32'h11111111);
    check("bad_store_err", 32'(resp_e[0]), 32'h1);
    drive(1'b0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    check("bad_store_nowrite", resp_d[0], 32'hDEADBEEF);
    drive(1'b0, 1'b1, 1'b1, 3'b010, 32'h30, 32'h12348765);
    drive(1'b0, 1'b1, 1'b0, 3'b001, 32'h31, 32'h0);
`ifdef RV_DMEM_MISALIGN_TRAP_EN
    check("lh_misalign_err", 32'(resp_e[0]), 32'h1);
    check("lh_misalign_rdata", resp_d[0], 32'h0);
`else
    check("lh_misalign_err", 32'(resp_e[0]), 32'h0);
    check("lh_misalign_rdata", resp_d[0], 32'hFFFF8765);
`endif

    drive(1'b0, 1'b1, 1'b1, 3'b010, 32'h40, 32'hCAFEF00D);
    drive(1'b0, 1'b1, 1'b0, 3'b010, 32'h40, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 3'b010, 32'h44, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h40, 32'h0);
    idle(5);
    drive(1'b0, 1'b1, 1'b0, 3'b010, 32'h40, 32'h0);
    check("post_reset_lw", resp_d[0], 32'hCAFEF00D);
    idle(4);

    for (int n = 0; n < 600; n++) begin
      w = ($urandom_range(0, 9) < 4);
      if ($urandom_range(0, 3) != 0) f3 = w ? 3'($urandom_range(0, 2)) : ld_ok[$urandom_range(0, 4)];
      else                          f3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 9))
        0:       a = 32'(4 * Depth) + 32'($urandom_range(0, 63));
        1:       a = $urandom;
        default: a = 32'($urandom_range(0, 4 * Depth - 1));
      endcase
      drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 9) < 8), w, f3, a, $urandom);
    end
    idle(6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
